// File: rtl/seq_detect_param.sv
// Serial pattern detector: one bit per rising edge of next, programmable pattern, overlap and lock-out.
// Latency 1 clk from the accepting edge; no backpressure, steps are simply ignored while locked.
module seq_detect_param #(
    parameter int                 PAT_LEN    = 4,
    parameter logic [PAT_LEN-1:0] PATTERN    = 4'b1011,
    parameter int                 OVERLAP    = 1,
    parameter int                 LOCK_AFTER = 0,
    parameter int                 CNT_W      = 8,
    parameter int                 PW         = $clog2(PAT_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             next,
    input  logic             in,
    input  logic             clear,
    output logic [PW-1:0]    state_display,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               next_last_q, next_last_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [PW-1:0]      vld_q, vld_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               step;
    logic               match_now;
    logic [PAT_LEN-1:0] hist_step;
    logic [PW-1:0]      vld_step;
    logic [CNT_W-1:0]   cnt_step;

    logic [PAT_LEN-1:0] mask;
    logic [PAT_LEN-1:0] pat_top;
    logic [PW-1:0]      prog;

    always_comb begin
        next_last_d = next;
        hist_d      = hist_q;
        vld_d       = vld_q;
        out_d       = out_q;
        cnt_d       = cnt_q;
        state_d     = state_q;

        step      = next && !next_last_q && (state_q != LOCKED);
        hist_step = {hist_q[PAT_LEN-2:0], in};
        vld_step  = (vld_q == PW'(PAT_LEN)) ? vld_q : vld_q + 1'b1;
        cnt_step  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        match_now = (vld_step == PW'(PAT_LEN)) && (hist_step == PATTERN);

        // clear wins over a coincident step; that step is lost
        if (clear) begin
            hist_d  = '0;
            vld_d   = '0;
            out_d   = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
        end else if (step) begin
            hist_d  = hist_step;
            vld_d   = vld_step;
            out_d   = match_now;
            state_d = RUN;
            if (match_now) begin
                cnt_d = cnt_step;
                if (OVERLAP == 0) begin
                    vld_d   = '0;
                    state_d = IDLE;
                end
                if (LOCK_AFTER != 0 && 32'(cnt_step) == LOCK_AFTER) begin
                    state_d = LOCKED;
                    out_d   = 1'b0;
                end
            end
        end
    end

    // Longest proper prefix of PATTERN that ends the valid history; longest k wins.
    always_comb begin
        prog    = '0;
        mask    = '0;
        pat_top = '0;
        for (int k = 1; k < PAT_LEN; k++) begin
            mask = '0;
            for (int j = 0; j < PAT_LEN; j++) begin
                if (j < k) mask[j] = 1'b1;
            end
            pat_top = PATTERN >> (PAT_LEN - k);
            if (PW'(k) <= vld_q && ((hist_q ^ pat_top) & mask) == '0) begin
                prog = PW'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            next_last_q <= 1'b0;
            hist_q      <= '0;
            vld_q       <= '0;
            out_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            next_last_q <= next_last_d;
            hist_q      <= hist_d;
            vld_q       <= vld_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
        end
    end

    assign state_display = (state_q == LOCKED) ? PW'(PAT_LEN) : prog;
    assign out           = out_q;
    assign match_count   = cnt_q;
    assign locked        = (state_q == LOCKED);

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector, the successor to the fixed seven-state sequence FSM. One bit of `in` is consumed per rising edge of the `next` step input. The block detects a programmable PAT_LEN-bit pattern, optionally with overlap, and reports match progress, a match count and an optional lock-out state. It sits behind the board button/switch inputs and drives the state display and match LED.

## Interface
- PAT_LEN, 4, pattern length in bits (2..16)
- PATTERN, 4'b1011, pattern; PATTERN[PAT_LEN-1] is the first bit expected
- OVERLAP, 1, 1: bits of a completed match may start the next match; 0: history discarded after a match
- LOCK_AFTER, 0, number of matches after which the block locks; 0 disables locking
- CNT_W, 8, width of match counter
- PW, $clog2(PAT_LEN+1), width of state_display (derived)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- next  in  1  step strobe, synchronous to clk; one step per 0->1 transition
- in  in  1  data bit sampled on an accepted step
- clear  in  1  synchronous clear of history, counter and lock
- state_display  out  PW  matched-prefix length (progress); PAT_LEN while locked
- out  out  1  high while the last accepted step completed a match
- match_count  out  CNT_W  saturating count of matches
- locked  out  1  lock-out state active

## Operation
- Edge detect: register `next_last`. A step is accepted in a cycle where next=1 and next_last=0. next_last <= next every cycle, including while locked.
- History: shift register `hist[PAT_LEN-1:0]`. On a step, hist <= {hist[PAT_LEN-2:0], in}, so hist[0] is the newest bit. The valid counter `vld` saturates at PAT_LEN.
- Match: on a step, match_now = (new vld == PAT_LEN) && (new hist == PATTERN).
- On match: out <= 1. match_count increments, saturating at all-ones. If OVERLAP=0, vld <= 0.
- On a non-matching step: out <= 0.
- Progress: state_display = largest k < PAT_LEN with k <= vld and hist[k-1:0] == PATTERN[PAT_LEN-1 -: k]; 0 if none. It is computed from registered hist/vld. Either a combinational priority search or a registered value is acceptable, provided the Timing section holds.
- States: IDLE (vld=0), RUN, LOCKED.
  - IDLE -> RUN on the first step.
  - RUN -> IDLE on a match with OVERLAP=0.
  - RUN -> LOCKED when LOCK_AFTER != 0 and the new match_count == LOCK_AFTER.
  - LOCKED: steps ignored; out=0; state_display=PAT_LEN; locked=1.
  - LOCKED -> IDLE only on clear or reset.
- clear: hist, vld, out, match_count and locked are zeroed and the state goes to IDLE. clear takes priority over a simultaneous step, and that step is dropped.
- Reset values: state_display=0, out=0, match_count=0, locked=0, hist=0, vld=0, next_last=0.

## Timing
- An accepted step at edge N is visible on out, state_display and match_count after edge N; latency is 1 clk from the sampling edge.
- out holds until the next accepted step or clear. It is a level signal, not a 1-cycle pulse.
- Holding next high is exactly one step. Toggling in without a next edge has no effect.
- Steps on consecutive cycles are impossible: a step needs next=0 in the previous cycle, so there are at most one step per 2 clk.
- Reset asserts asynchronously mid-sequence: outputs clear immediately without waiting for clk. Release is synchronous to the next clk edge.
- locked and out are updated in the same edge as the final match: locked=1 and out=0 after that edge. The match is counted.

## Test plan
- Reset: hold reset=0 with random next/in -> all outputs 0. Assert reset low between clk edges mid-run -> outputs 0 before the next edge.
- Basic match, PATTERN=1011, OVERLAP=1: steps 1,0,1,1 -> state_display 1,2,3, then out=1, match_count=1, state_display=1.
- Overlap: continue with steps 0,1,1 -> second match on the third step, match_count=2. The same stream with OVERLAP=0 -> no match on those 3 steps; the match needs the full 1,0,1,1.
- Step qualification: next held high 10 clk with in toggling -> exactly one bit consumed. next pulsed 0/1 alternately -> one step per rising edge.
- Lock, LOCK_AFTER=2: after the second match -> locked=1, out=0, state_display=4. Further steps give no change. clear=1 -> all zero, IDLE.
- Priority: clear and a next rising edge in the same cycle -> history cleared, step dropped (vld=0). match_count saturation with CNT_W=2 -> stays at 3 after 4+ matches.
